// File: rtl/l2_arbiter.sv
// -----------------------------------------------------------------------------
// l2_arbiter
//
// Two-port round-robin arbiter placing the instruction-side (port 0) and
// data-side (port 1) L1 caches in front of a single-request L2 cache.
// One transaction is in flight at a time. Its address, write flag and write
// data are latched at grant and held until the next grant. The transaction is
// offered to the L2 while in ISSUE until the L2 signals ready. The response
// comes back in WAIT and is returned to the owning port. A watchdog in WAIT
// ends a hung transaction with an error response.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   pN_valid/addr/is_write/w_data   request from L1 port N (held until ack)
//   pN_ack                   one-cycle pulse: request latched
//   pN_resp_valid            one-cycle pulse: response available
//   pN_resp_hit/err/r_data   response fields, held until next response
//   l2_mem_ready             L2 accepts a request only while high
//   l2_req_valid/addr/is_write/w_data   request to L2 (valid in ISSUE)
//   l2_resp_valid/hit/data   response pulse from L2
// -----------------------------------------------------------------------------
module l2_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64   // legal range 2..255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p0_valid,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic                  p0_is_write,
    input  logic [DATA_WIDTH-1:0] p0_w_data,
    output logic                  p0_ack,
    output logic                  p0_resp_valid,
    output logic                  p0_resp_hit,
    output logic                  p0_resp_err,
    output logic [DATA_WIDTH-1:0] p0_r_data,

    input  logic                  p1_valid,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  p1_is_write,
    input  logic [DATA_WIDTH-1:0] p1_w_data,
    output logic                  p1_ack,
    output logic                  p1_resp_valid,
    output logic                  p1_resp_hit,
    output logic                  p1_resp_err,
    output logic [DATA_WIDTH-1:0] p1_r_data,

    input  logic                  l2_mem_ready,
    output logic                  l2_req_valid,
    output logic [ADDR_WIDTH-1:0] l2_req_addr,
    output logic                  l2_req_is_write,
    output logic [DATA_WIDTH-1:0] l2_req_w_data,
    input  logic                  l2_resp_valid,
    input  logic                  l2_resp_hit,
    input  logic [DATA_WIDTH-1:0] l2_resp_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // The watchdog fires on the cycle the timer reaches TIMEOUT-1, so an
    // 8-bit timer never wraps for any legal TIMEOUT.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic       owner;          // port that owns the in-flight transaction
    logic       last_gnt;       // port granted most recently
    logic [7:0] timer;

    logic       grant;          // a request is taken this cycle
    logic       grant_port;     // which port is taken
    logic       resp_take;      // L2 response accepted this cycle
    logic       resp_timeout;   // watchdog expired this cycle
    logic       resp_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and per-cycle decisions
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        grant        = 1'b0;
        grant_port   = 1'b0;
        resp_take    = 1'b0;
        resp_timeout = 1'b0;

        case (state)
            IDLE: begin
                if (p0_valid || p1_valid) begin
                    grant      = 1'b1;
                    // On a tie the port that did not win last time goes next.
                    grant_port = (p0_valid && p1_valid) ? ~last_gnt : p1_valid;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (l2_mem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A real response on the watchdog's last cycle still wins.
                if (l2_resp_valid) begin
                    resp_take  = 1'b1;
                    state_next = IDLE;
                end else if (timer == TIMER_LAST) begin
                    resp_timeout = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign resp_done    = resp_take | resp_timeout;
    assign l2_req_valid = (state == ISSUE);

    // ------------------------------------------------------------------
    // Grant bookkeeping and latched request fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner           <= 1'b0;
            last_gnt        <= 1'b1;   // port 0 wins the first tie
            l2_req_addr     <= '0;
            l2_req_is_write <= 1'b0;
            l2_req_w_data   <= '0;
        end else if (grant) begin
            owner           <= grant_port;
            last_gnt        <= grant_port;
            l2_req_addr     <= grant_port ? p1_addr     : p0_addr;
            l2_req_is_write <= grant_port ? p1_is_write : p0_is_write;
            l2_req_w_data   <= grant_port ? p1_w_data   : p0_w_data;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog timer: cleared on the ISSUE->WAIT edge, counts in WAIT
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= 8'd0;
        end else if (state == ISSUE && l2_mem_ready) begin
            timer <= 8'd0;
        end else if (state == WAIT) begin
            timer <= timer + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Ack and response-valid pulses, owner port only
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_ack        <= 1'b0;
            p1_ack        <= 1'b0;
            p0_resp_valid <= 1'b0;
            p1_resp_valid <= 1'b0;
        end else begin
            p0_ack        <= grant & ~grant_port;
            p1_ack        <= grant & grant_port;
            p0_resp_valid <= resp_done & ~owner;
            p1_resp_valid <= resp_done & owner;
        end
    end

    // ------------------------------------------------------------------
    // Per-port response fields; held until that port's next response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_r_data   <= '0;
            p0_resp_hit <= 1'b0;
            p0_resp_err <= 1'b0;
        end else if (resp_done && !owner) begin
            p0_r_data   <= resp_take ? l2_resp_data : '0;
            p0_resp_hit <= resp_take & l2_resp_hit;
            p0_resp_err <= resp_timeout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_r_data   <= '0;
            p1_resp_hit <= 1'b0;
            p1_resp_err <= 1'b0;
        end else if (resp_done && owner) begin
            p1_r_data   <= resp_take ? l2_resp_data : '0;
            p1_resp_hit <= resp_take & l2_resp_hit;
            p1_resp_err <= resp_timeout;
        end
    end

endmodule
